// File: rtl/cpu_pkg.sv
// Shared constants, opcode map and sequencer state encoding for the CPU control slice.
package cpu_pkg;

    localparam int REG_AW  = 5;
    localparam int IMM_W   = 8;
    localparam int INSTR_W = 32;
    localparam int OPC_W   = 4;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'hD;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hE;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,  // waiting for start after reset
        ST_FETCH  = 3'd1,  // instruction memory read issued at pc
        ST_LOAD   = 3'd2,  // read data captured into ir
        ST_DECODE = 3'd3,  // CU fields latched, branch on opcode
        ST_EXEC   = 3'd4,  // ALU launched, waiting for alu_done
        ST_WB     = 3'd5,  // register write-back, pc advances
        ST_HALTED = 3'd6   // HALT retired, waiting for restart
    } seq_state_e;

    function automatic logic state_is_busy(input seq_state_e s);
        return !(s == ST_IDLE || s == ST_HALTED);
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller; owns the pc and sequences
// instruction memory, register file and ALU around the external CU decoder.
module instr_sequencer #(
    parameter int         PC_W    = 8,
    parameter logic [3:0] OP_HALT = 4'b1111,
    parameter logic [3:0] OP_JMP  = 4'b1110,
    parameter logic [3:0] OP_LDI  = 4'b1101
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        imem_en,
    output logic [PC_W-1:0]             imem_addr,
    input  logic [cpu_pkg::INSTR_W-1:0] imem_data,
    output logic [cpu_pkg::INSTR_W-1:0] ir,
    input  logic [cpu_pkg::OPC_W-1:0]   opcode,
    input  logic [cpu_pkg::REG_AW-1:0]  addr1,
    input  logic [cpu_pkg::REG_AW-1:0]  addr2,
    input  logic [cpu_pkg::REG_AW-1:0]  addr3,
    input  logic [cpu_pkg::IMM_W-1:0]   number,
    output logic [cpu_pkg::REG_AW-1:0]  rf_raddr1,
    output logic [cpu_pkg::REG_AW-1:0]  rf_raddr2,
    output logic [cpu_pkg::REG_AW-1:0]  rf_waddr,
    output logic                        rf_we,
    output logic                        rf_wsel,
    output logic [cpu_pkg::IMM_W-1:0]   imm_out,
    output logic [cpu_pkg::OPC_W-1:0]   alu_op,
    output logic                        alu_start,
    input  logic                        alu_done,
    output logic                        busy,
    output logic                        halted,
    output logic [PC_W-1:0]             pc,
    output logic [15:0]                 retired
);
    import cpu_pkg::*;

    seq_state_e              state_q, state_d;
    logic [PC_W-1:0]         pc_q, pc_d;
    logic [15:0]             retired_q, retired_d;
    logic [INSTR_W-1:0]      ir_q, ir_d;
    logic [OPC_W-1:0]        op_q, op_d;
    logic [REG_AW-1:0]       a1_q, a1_d;
    logic [REG_AW-1:0]       a2_q, a2_d;
    logic [REG_AW-1:0]       a3_q, a3_d;
    logic [IMM_W-1:0]        num_q, num_d;
    logic                    wsel_q, wsel_d;
    logic                    imem_en_q;
    logic                    alu_start_q;
    logic [OPC_W-1:0]        alu_op_q;
    logic                    rf_we_q;
    logic                    busy_q;
    logic                    halted_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        ir_d      = ir_q;
        op_d      = op_q;
        a1_d      = a1_q;
        a2_d      = a2_q;
        a3_d      = a3_q;
        num_d     = num_q;
        wsel_d    = wsel_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                ir_d    = imem_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                op_d   = opcode;
                a1_d   = addr1;
                a2_d   = addr2;
                a3_d   = addr3;
                num_d  = number;
                wsel_d = (opcode == OP_LDI);
                if (opcode == OP_HALT) begin
                    state_d   = ST_HALTED;
                    retired_d = retired_q + 16'd1;
                end else if (opcode == OP_JMP) begin
                    state_d   = ST_FETCH;
                    pc_d      = PC_W'(number);
                    retired_d = retired_q + 16'd1;
                end else if (opcode == OP_LDI) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            // alu_start_q marks the launch cycle, where alu_done is not yet trusted
            ST_EXEC: begin
                if (!alu_start_q && alu_done) state_d = ST_WB;
            end
            ST_WB: begin
                state_d   = ST_FETCH;
                pc_d      = pc_q + PC_W'(1);
                retired_d = retired_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            retired_q   <= '0;
            ir_q        <= '0;
            op_q        <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            num_q       <= '0;
            wsel_q      <= 1'b0;
            imem_en_q   <= 1'b0;
            alu_start_q <= 1'b0;
            alu_op_q    <= '0;
            rf_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            retired_q   <= retired_d;
            ir_q        <= ir_d;
            op_q        <= op_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            a3_q        <= a3_d;
            num_q       <= num_d;
            wsel_q      <= wsel_d;
            imem_en_q   <= (state_d == ST_FETCH);
            alu_start_q <= (state_d == ST_EXEC) && (state_q != ST_EXEC);
            alu_op_q    <= (state_d == ST_EXEC) ? op_d : '0;
            rf_we_q     <= (state_d == ST_WB);
            busy_q      <= state_is_busy(state_d);
            halted_q    <= (state_d == ST_HALTED);
        end
    end

    // Read ports follow the CU live during DECODE, then hold the latched copy through WB.
    assign rf_raddr1 = (state_q == ST_DECODE) ? addr2 : a2_q;
    assign rf_raddr2 = (state_q == ST_DECODE) ? addr3 : a3_q;

    assign imem_en   = imem_en_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign retired   = retired_q;
    assign rf_waddr  = a1_q;
    assign rf_we     = rf_we_q;
    assign rf_wsel   = wsel_q;
    assign imm_out   = num_q;
    assign alu_op    = alu_op_q;
    assign alu_start = alu_start_q;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer with a CU stand-in, instruction memory,
// a delayed-done ALU responder and an instruction-level reference model.
module tb_instr_sequencer;

    localparam int         PC_W   = 8;
    localparam logic [3:0] T_HALT = 4'hF;
    localparam logic [3:0] T_JMP  = 4'hE;
    localparam logic [3:0] T_LDI  = 4'hD;
    localparam logic [3:0] T_ADD  = 4'h0;
    localparam logic [3:0] T_SUB  = 4'h1;

    logic            clk = 1'b0;
    logic            reset, start, alu_done;
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data = 32'h0;
    logic [31:0]     ir;
    logic [3:0]      opcode;
    logic [4:0]      addr1, addr2, addr3;
    logic [7:0]      number;
    logic [4:0]      rf_raddr1, rf_raddr2, rf_waddr;
    logic            rf_we, rf_wsel;
    logic [7:0]      imm_out;
    logic [3:0]      alu_op;
    logic            alu_start, busy, halted;
    logic [PC_W-1:0] pc;
    logic [15:0]     retired;

    logic [31:0] imem [256];
    int          alu_delays [64];
    bit          alu_spur [64];

    typedef struct { int cyc; logic [4:0] wa; logic ws; logic [7:0] imm; logic [4:0] ra1; logic [4:0] ra2; } wr_t;
    typedef struct { int cyc; logic [3:0] op; logic [4:0] ra1; logic [4:0] ra2; } alu_t;

    wr_t  exp_wr[$];
    alu_t exp_alu[$];
    int   exp_end, exp_pc, exp_ret;
    bit   exp_halt;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // CU stand-in: fixed field layout of the instruction word
    assign opcode = ir[31:28];
    assign addr1  = ir[27:23];
    assign addr2  = ir[22:18];
    assign addr3  = ir[17:13];
    assign number = ir[7:0];

    always @(posedge clk) if (imem_en) imem_data <= imem[imem_addr];

    instr_sequencer #(.PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data), .ir(ir),
        .opcode(opcode), .addr1(addr1), .addr2(addr2), .addr3(addr3), .number(number),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .imm_out(imm_out),
        .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
        .busy(busy), .halted(halted), .pc(pc), .retired(retired)
    );

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] a1, input logic [4:0] a2,
                                        input logic [4:0] a3, input logic [7:0] n);
        return {op, a1, a2, a3, 5'd0, n};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = enc(T_HALT, 5'd0, 5'd0, 5'd0, 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; alu_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Instruction-level model: cycle 1 is the first FETCH after start is sampled.
    task automatic model_run(input int max_instr);
        int p, r, c, k, d;
        logic [31:0] w;
        logic [3:0] op;
        logic [4:0] a1, a2, a3;
        logic [7:0] n;
        exp_wr.delete(); exp_alu.delete(); exp_halt = 0;
        p = 0; r = 0; c = 1; k = 0;
        for (int i = 0; i < max_instr; i++) begin
            w = imem[p]; op = w[31:28]; a1 = w[27:23]; a2 = w[22:18]; a3 = w[17:13]; n = w[7:0];
            if (op == T_HALT) begin
                r++; exp_halt = 1; c += 3;
                break;
            end else if (op == T_JMP) begin
                r++; p = int'(n); c += 3;
            end else if (op == T_LDI) begin
                exp_wr.push_back('{c + 3, a1, 1'b1, n, a2, a3});
                r++; p = (p + 1) % 256; c += 4;
            end else begin
                d = alu_delays[k]; k++;
                exp_alu.push_back('{c + 3, op, a2, a3});
                exp_wr.push_back('{c + 4 + d, a1, 1'b0, n, a2, a3});
                r++; p = (p + 1) % 256; c += 5 + d;
            end
        end
        exp_end = c; exp_pc = p; exp_ret = r;
    endtask

    task automatic run_prog(input int max_instr, input bit poke_start);
        int cyc, done_at, spur_at, k, halt_first;
        wr_t  ow[$];
        alu_t oa[$];
        model_run(max_instr);
        cyc = 0; done_at = -1; spur_at = -1; k = 0; halt_first = -1;
        @(negedge clk);
        start = 1'b1;
        while (cyc < exp_end) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                n_checks++;
                if ({imem_en, busy, imem_addr} !== {1'b1, 1'b1, 8'd0}) begin
                    n_fail++;
                    $display("FAIL fetch_start: got en/busy/addr=%b/%b/%h expected 1/1/00", imem_en, busy, imem_addr);
                end
            end
            if (rf_we) ow.push_back('{cyc, rf_waddr, rf_wsel, imm_out, rf_raddr1, rf_raddr2});
            if (alu_start) begin
                oa.push_back('{cyc, alu_op, rf_raddr1, rf_raddr2});
                done_at = cyc + alu_delays[k % 64];
                spur_at = alu_spur[k % 64] ? cyc : -1;
                k++;
                if (poke_start) start = 1'b1;
            end
            if (halted && halt_first < 0) halt_first = cyc;
            alu_done = (cyc == done_at) || (cyc == spur_at);
        end
        alu_done = 1'b0;
        start = 1'b0;

        n_checks++;
        if (ow.size() != exp_wr.size()) begin
            n_fail++;
            $display("FAIL wb_count: got %0d expected %0d", ow.size(), exp_wr.size());
        end
        for (int i = 0; i < ow.size() && i < exp_wr.size(); i++) begin
            n_checks++;
            if ({ow[i].cyc, ow[i].wa, ow[i].ws, ow[i].imm, ow[i].ra1, ow[i].ra2} !==
                {exp_wr[i].cyc, exp_wr[i].wa, exp_wr[i].ws, exp_wr[i].imm, exp_wr[i].ra1, exp_wr[i].ra2}) begin
                n_fail++;
                $display("FAIL wb[%0d]: got cyc=%0d wa=%0d ws=%0d imm=%h ra=%0d/%0d expected cyc=%0d wa=%0d ws=%0d imm=%h ra=%0d/%0d",
                         i, ow[i].cyc, ow[i].wa, ow[i].ws, ow[i].imm, ow[i].ra1, ow[i].ra2,
                         exp_wr[i].cyc, exp_wr[i].wa, exp_wr[i].ws, exp_wr[i].imm, exp_wr[i].ra1, exp_wr[i].ra2);
            end
        end
        n_checks++;
        if (oa.size() != exp_alu.size()) begin
            n_fail++;
            $display("FAIL alu_count: got %0d expected %0d", oa.size(), exp_alu.size());
        end
        for (int i = 0; i < oa.size() && i < exp_alu.size(); i++) begin
            n_checks++;
            if ({oa[i].cyc, oa[i].op, oa[i].ra1, oa[i].ra2} !== {exp_alu[i].cyc, exp_alu[i].op, exp_alu[i].ra1, exp_alu[i].ra2}) begin
                n_fail++;
                $display("FAIL alu[%0d]: got cyc=%0d op=%h ra=%0d/%0d expected cyc=%0d op=%h ra=%0d/%0d",
                         i, oa[i].cyc, oa[i].op, oa[i].ra1, oa[i].ra2,
                         exp_alu[i].cyc, exp_alu[i].op, exp_alu[i].ra1, exp_alu[i].ra2);
            end
        end
        n_checks++;
        if (exp_halt) begin
            if (halt_first !== exp_end) begin
                n_fail++;
                $display("FAIL halt_cycle: got %0d expected %0d", halt_first, exp_end);
            end
        end else if (halt_first != -1) begin
            n_fail++;
            $display("FAIL no_halt: got halted at cycle %0d expected never", halt_first);
        end
        n_checks++;
        if ({pc, retired, busy} !== {PC_W'(exp_pc), 16'(exp_ret), !exp_halt}) begin
            n_fail++;
            $display("FAIL end_state: got pc=%h retired=%0d busy=%b expected pc=%h retired=%0d busy=%b",
                     pc, retired, busy, PC_W'(exp_pc), exp_ret, !exp_halt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(1, 0));
            alu_done = 1'($urandom_range(1, 0));
            #1;
            n_checks++;
            if ({pc, ir, retired, imem_en, imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we, rf_wsel,
                 imm_out, alu_op, alu_start, busy, halted} !== 97'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected 0",
                         {pc, ir, retired, imem_en, imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we, rf_wsel,
                          imm_out, alu_op, alu_start, busy, halted});
            end
        end
        @(negedge clk);
        start = 1'b0; alu_done = 1'b0; reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, imem_en, pc} !== {1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b en=%b pc=%h expected 0/0/00", busy, imem_en, pc);
        end
    endtask

    task automatic test_ldi();
        do_reset();
        clear_imem();
        imem[0] = enc(T_LDI, 5'd3, 5'd0, 5'd0, 8'h5A);
        run_prog(10, 1'b0);
        n_checks++;
        if ({halted, pc, retired} !== {1'b1, 8'd1, 16'd2}) begin
            n_fail++;
            $display("FAIL ldi_halt: got halted=%b pc=%h retired=%0d expected 1/01/2", halted, pc, retired);
        end
    endtask

    task automatic test_alu_delay();
        do_reset();
        clear_imem();
        imem[0] = enc(T_ADD, 5'd1, 5'd2, 5'd4, 8'h00);
        alu_delays[0] = 5; alu_spur[0] = 1'b0;
        @(negedge clk); alu_done = 1'b1;
        @(negedge clk);
        @(negedge clk); alu_done = 1'b0;
        n_checks++;
        if ({busy, imem_en, alu_start, rf_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_ignores_done: got busy/en/start/we=%b expected 0000", {busy, imem_en, alu_start, rf_we});
        end
        run_prog(10, 1'b0);
    endtask

    task automatic test_jmp_wrap();
        do_reset();
        clear_imem();
        imem[0]   = enc(T_JMP, 5'd0, 5'd0, 5'd0, 8'hFF);
        imem[255] = enc(T_LDI, 5'd7, 5'd1, 5'd2, 8'h33);
        run_prog(2, 1'b0);
        n_checks++;
        if ({pc, imem_addr, imem_en} !== {8'h00, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL pc_wrap: got pc=%h addr=%h en=%b expected 00/00/1", pc, imem_addr, imem_en);
        end
        do_reset();
    endtask

    task automatic test_restart();
        do_reset();
        clear_imem();
        imem[0] = enc(T_SUB, 5'd5, 5'd6, 5'd7, 8'h11);
        imem[1] = enc(T_LDI, 5'd2, 5'd3, 5'd4, 8'h44);
        alu_delays[0] = 2; alu_spur[0] = 1'b1;
        run_prog(10, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({pc, retired, halted, busy, imem_en} !== {8'd0, 16'd0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL restart_from_halt: got pc=%h retired=%0d halted=%b busy=%b en=%b expected 00/0/0/1/1",
                     pc, retired, halted, busy, imem_en);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_wb();
        bit seen;
        do_reset();
        clear_imem();
        imem[0] = enc(T_LDI, 5'd9, 5'd0, 5'd0, 8'h77);
        seen = 0;
        @(negedge clk); start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (rf_we) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wb_reached: got no rf_we within 20 cycles expected one");
        end else begin
            reset = 1'b1;
            #1;
            n_checks++;
            if ({rf_we, busy, pc} !== {1'b0, 1'b0, 8'd0}) begin
                n_fail++;
                $display("FAIL reset_in_wb: got we=%b busy=%b pc=%h expected 0/0/00", rf_we, busy, pc);
            end
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk);
            #1;
            n_checks++;
            if ({rf_we, busy, pc} !== {1'b0, 1'b0, 8'd0}) begin
                n_fail++;
                $display("FAIL after_release: got we=%b busy=%b pc=%h expected 0/0/00", rf_we, busy, pc);
            end
        end
    endtask

    task automatic test_random();
        int len, r, tgt;
        for (int t = 0; t < 4; t++) begin
            do_reset();
            clear_imem();
            len = 6 + $urandom_range(4, 0);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(9, 0);
                if (r < 3) begin
                    imem[i] = enc(T_LDI, 5'($urandom), 5'($urandom), 5'($urandom), 8'($urandom));
                end else if (r < 4) begin
                    tgt = i + 1 + $urandom_range(1, 0);
                    if (tgt > len) tgt = len;
                    imem[i] = enc(T_JMP, 5'($urandom), 5'($urandom), 5'($urandom), 8'(tgt));
                end else begin
                    imem[i] = enc(4'($urandom_range(12, 0)), 5'($urandom), 5'($urandom), 5'($urandom), 8'($urandom));
                end
            end
            for (int i = 0; i < 64; i++) begin
                alu_delays[i] = $urandom_range(6, 1);
                alu_spur[i]   = 1'($urandom_range(1, 0));
            end
            run_prog(64, 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; alu_done = 1'b0;
        clear_imem();
        for (int i = 0; i < 64; i++) begin
            alu_delays[i] = 1;
            alu_spur[i]   = 1'b0;
        end
        test_reset();
        test_ldi();
        test_alu_delay();
        test_jmp_wrap();
        test_restart();
        test_reset_mid_wb();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
